// File: rtl/morse_pkg.sv
// Shared types and the letter table for the Morse message sequencer.
// The table holds the A-H patterns as {code[3:0], len[2:0]}, sent MSB-first from bit len-1.
package morse_pkg;

    localparam int LETTER_W = 3;
    localparam int TICK_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MARK,
        SPACE,
        LGAP
    } state_e;

    typedef struct packed {
        logic [3:0] code;
        logic [2:0] len;
    } letter_code_t;

    // 1 = dash, 0 = dot.
    localparam logic [6:0] LETTER_TABLE [8] = '{
        {4'b0001, 3'd2},
        {4'b1000, 3'd4},
        {4'b1010, 3'd4},
        {4'b0100, 3'd3},
        {4'b0000, 3'd1},
        {4'b0010, 3'd4},
        {4'b0110, 3'd3},
        {4'b0000, 3'd4}
    };

    function automatic letter_code_t letter_lookup(input logic [LETTER_W-1:0] idx);
        return letter_code_t'(LETTER_TABLE[idx]);
    endfunction

endpackage

// File: rtl/morse_letter_fifo.sv
// Small FIFO of letter indices; a push is accepted only when not full before the edge,
// even if a pop happens on the same edge.
module morse_letter_fifo
    import morse_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [LETTER_W-1:0]       data_in,
    output logic [LETTER_W-1:0]       data_out,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [LETTER_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/morse_sequencer.sv
// Queues letter selections and plays them back as tick-paced dot/dash strobes,
// owning symbol and letter spacing and flagging when the queue drains.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int DEPTH            = 4,
    parameter int DOT_TICKS        = 1,
    parameter int DASH_TICKS       = 3,
    parameter int GAP_TICKS        = 1,
    parameter int LETTER_GAP_TICKS = 3
) (
    input  logic                      CLOCK50_i,
    input  logic                      rst_i,
    input  logic                      tick_i,
    input  logic                      push_i,
    input  logic [2:0]                letter_i,
    input  logic                      abort_i,
    output logic                      dot_o,
    output logic                      dash_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      full_o,
    output logic                      overflow_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    state_e              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [TICK_W-1:0]   seg_len;
    logic [1:0]          sym_idx;
    logic [3:0]          code_r;
    logic [LETTER_W-1:0] letter_r;
    letter_code_t        load_entry;
    logic [1:0]          load_top;
    logic                tick_done;
    logic                pop;
    logic [LETTER_W-1:0] fifo_data;
    logic                fifo_full;
    logic                fifo_empty;

    morse_letter_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (CLOCK50_i),
        .rst      (rst_i),
        .push     (push_i && !abort_i),
        .pop      (pop),
        .flush    (abort_i),
        .data_in  (letter_i),
        .data_out (fifo_data),
        .count    (count_o),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign full_o = fifo_full;
    assign busy_o = (state != IDLE);

    // tick_done marks the edge sampling the last tick of the current timed state.
    always_comb begin
        seg_len = TICK_W'(DOT_TICKS);
        case (state)
            MARK:    seg_len = code_r[sym_idx] ? TICK_W'(DASH_TICKS) : TICK_W'(DOT_TICKS);
            SPACE:   seg_len = TICK_W'(GAP_TICKS);
            LGAP:    seg_len = TICK_W'(LETTER_GAP_TICKS);
            default: seg_len = TICK_W'(DOT_TICKS);
        endcase
        tick_done  = tick_i && (state == MARK || state == SPACE || state == LGAP)
                     && (tick_cnt == seg_len - 1'b1);
        pop        = !abort_i && !fifo_empty
                     && (state == IDLE || (state == LGAP && tick_done));
        load_entry = letter_lookup(letter_r);
        load_top   = 2'(load_entry.len - 3'd1);
    end

    always_ff @(posedge CLOCK50_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            sym_idx    <= '0;
            code_r     <= '0;
            letter_r   <= '0;
            dot_o      <= 1'b0;
            dash_o     <= 1'b0;
            done_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            overflow_o <= push_i && !abort_i && fifo_full;
            if (abort_i) begin
                state    <= IDLE;
                tick_cnt <= '0;
                dot_o    <= 1'b0;
                dash_o   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            letter_r <= fifo_data;
                            state    <= LOAD;
                        end
                    end
                    LOAD: begin
                        code_r   <= load_entry.code;
                        sym_idx  <= load_top;
                        tick_cnt <= '0;
                        dash_o   <= load_entry.code[load_top];
                        dot_o    <= ~load_entry.code[load_top];
                        state    <= MARK;
                    end
                    MARK: begin
                        if (tick_done) begin
                            tick_cnt <= '0;
                            dot_o    <= 1'b0;
                            dash_o   <= 1'b0;
                            if (sym_idx == 2'd0) begin
                                state <= LGAP;
                            end else begin
                                sym_idx <= sym_idx - 1'b1;
                                state   <= SPACE;
                            end
                        end else if (tick_i) begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    SPACE: begin
                        if (tick_done) begin
                            tick_cnt <= '0;
                            dash_o   <= code_r[sym_idx];
                            dot_o    <= ~code_r[sym_idx];
                            state    <= MARK;
                        end else if (tick_i) begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    LGAP: begin
                        if (tick_done) begin
                            tick_cnt <= '0;
                            if (pop) begin
                                letter_r <= fifo_data;
                                state    <= LOAD;
                            end else begin
                                state  <= IDLE;
                                done_o <= 1'b1;
                            end
                        end else if (tick_i) begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
